// File: rtl/id_pkg.sv
// Shared definitions for the parametrised instruction-decode stage.
// Holds the opcode map, ALU operation codes, the ID FSM state type, the
// decoder control bundle and the control part of the EX pipeline word.
package id_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd9;
    localparam logic [3:0] OP_LOAD  = 4'd10;
    localparam logic [3:0] OP_STORE = 4'd11;
    localparam logic [3:0] OP_BEQZ  = 4'd12;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } id_state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       wb_en;
        logic       wb_sel;
        logic       mem_we;
        logic       use_imm;
        logic       use_rs;
        logic       use_rt;
        logic       is_branch;
        logic       illegal;
    } dec_ctrl_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       mem_we;
        logic       wb_en;
        logic       wb_sel;
    } ex_ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Purely combinational opcode decoder.
// Ports:
//   op_i    opcode field of the instruction held in the D register
//   ctrl_o  control bundle (ALU op, writeback/memory controls, operand usage,
//           branch and illegal flags)
// Opcodes wider than 4 bits with any upper bit set are illegal.
module id_decoder
    import id_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op_i,
    output dec_ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        if ((op_i >> 4) != '0) begin
            ctrl_o.illegal = 1'b1;
        end else begin
            case (op_i[3:0])
                OP_NOP: ;
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                    ctrl_o.alu_op = op_i[2:0];
                    ctrl_o.wb_en  = 1'b1;
                    ctrl_o.use_rs = 1'b1;
                    ctrl_o.use_rt = 1'b1;
                end
                OP_ADDI: begin
                    ctrl_o.alu_op  = ALU_ADD;
                    ctrl_o.wb_en   = 1'b1;
                    ctrl_o.use_imm = 1'b1;
                    ctrl_o.use_rs  = 1'b1;
                end
                OP_LOAD: begin
                    ctrl_o.alu_op  = ALU_ADD;
                    ctrl_o.wb_en   = 1'b1;
                    ctrl_o.wb_sel  = 1'b1;
                    ctrl_o.use_imm = 1'b1;
                    ctrl_o.use_rs  = 1'b1;
                end
                // STORE reads its data register through the rt port (rd field).
                OP_STORE: begin
                    ctrl_o.alu_op  = ALU_ADD;
                    ctrl_o.mem_we  = 1'b1;
                    ctrl_o.use_imm = 1'b1;
                    ctrl_o.use_rs  = 1'b1;
                    ctrl_o.use_rt  = 1'b1;
                end
                OP_BEQZ: begin
                    ctrl_o.use_rs    = 1'b1;
                    ctrl_o.is_branch = 1'b1;
                end
                default: ctrl_o.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/id_stage_param.sv
// Parametrised instruction-decode stage between IF and EX.
// Ports:
//   clk, rst                 clock / asynchronous active-low reset
//   in_valid/in_ready/in_instr   IF handshake and instruction word
//   rf_addr1/2, rf_data1/2   register-file read port (same-cycle data)
//   ex_is_load, ex_rd        EX-stage instruction info for load-use stalls
//   out_valid/out_ready, out_*   EX pipeline word and handshake
//   branch_taken/offset      one-cycle registered redirect
//   illegal, stall_count     sticky illegal flag, saturating stall counter
module id_stage_param
    import id_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int RA_W   = 3,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W+4*RA_W-1:0] in_instr,
    output logic [RA_W-1:0]        rf_addr1,
    output logic [RA_W-1:0]        rf_addr2,
    input  logic [DATA_W-1:0]      rf_data1,
    input  logic [DATA_W-1:0]      rf_data2,
    input  logic                   ex_is_load,
    input  logic [RA_W-1:0]        ex_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_alu_op,
    output logic [DATA_W-1:0]      out_src_a,
    output logic [DATA_W-1:0]      out_src_b,
    output logic [DATA_W-1:0]      out_store_data,
    output logic                   out_mem_we,
    output logic                   out_wb_en,
    output logic                   out_wb_sel,
    output logic [RA_W-1:0]        out_rd,
    output logic [RA_W-1:0]        out_rs1,
    output logic [RA_W-1:0]        out_rs2,
    output logic                   branch_taken,
    output logic [DATA_W-1:0]      branch_offset,
    output logic                   illegal,
    output logic [CNT_W-1:0]       stall_count
);

    localparam int INSTR_W = OP_W + 4*RA_W;
    localparam int IMM_W   = 2*RA_W;

    typedef struct packed {
        ex_ctrl_t          ctrl;
        logic [DATA_W-1:0] src_a;
        logic [DATA_W-1:0] src_b;
        logic [DATA_W-1:0] store_data;
        logic [RA_W-1:0]   rd;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
    } ex_word_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [INSTR_W-1:0] d_instr_q, d_instr_d;
    logic               d_valid_q, d_valid_d;
    ex_word_t           word_q, word_d, next_word;
    logic               out_valid_q, out_valid_d;
    logic               br_taken_q, br_taken_d;
    logic [DATA_W-1:0]  br_off_q, br_off_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    id_state_e          state_q;

    logic [OP_W-1:0]  op_f;
    logic [RA_W-1:0]  rd_f, rs_f, rt_f;
    logic [IMM_W-1:0] imm_f;
    dec_ctrl_t        dec;
    logic             run, hazard, br_resolve, br_cond, issue, accept;

    assign op_f  = d_instr_q[INSTR_W-1 -: OP_W];
    assign rd_f  = d_instr_q[INSTR_W-OP_W-1 -: RA_W];
    assign rs_f  = d_instr_q[INSTR_W-OP_W-RA_W-1 -: RA_W];
    assign rt_f  = d_instr_q[INSTR_W-OP_W-2*RA_W-1 -: RA_W];
    assign imm_f = d_instr_q[IMM_W-1:0];

    id_decoder #(.OP_W(OP_W)) u_dec (
        .op_i   (op_f),
        .ctrl_o (dec)
    );

    // ---- D stage: register-file read, hazard and handshake control ----
    assign rf_addr1 = rs_f;
    assign rf_addr2 = dec.mem_we ? rd_f : rt_f;

    always_comb begin
        run    = (state_q == ST_RUN);
        hazard = d_valid_q && ex_is_load && (ex_rd != '0) &&
                 ((dec.use_rs && ex_rd == rf_addr1) || (dec.use_rt && ex_rd == rf_addr2));
        // A branch waiting on a load result must not resolve with stale data.
        br_resolve = run && d_valid_q && dec.is_branch && !hazard;
        br_cond    = (rf_data1 == '0);
        issue      = run && d_valid_q && !hazard && !dec.is_branch && (!out_valid_q || out_ready);
        in_ready   = rst && run && (!d_valid_q || issue || br_resolve) && !(d_valid_q && dec.is_branch);
        accept     = in_valid && in_ready;
    end

    always_comb begin
        next_word              = '0;
        next_word.ctrl.alu_op  = dec.alu_op;
        next_word.ctrl.mem_we  = dec.mem_we;
        next_word.ctrl.wb_en   = dec.wb_en;
        next_word.ctrl.wb_sel  = dec.wb_sel;
        next_word.src_a        = rf_data1;
        next_word.src_b        = dec.use_imm ? sext_imm(imm_f) : rf_data2;
        next_word.store_data   = dec.mem_we ? rf_data2 : '0;
        next_word.rd           = dec.wb_en ? rd_f : '0;
        next_word.rs1          = dec.use_rs ? rs_f : '0;
        next_word.rs2          = dec.use_rt ? rf_addr2 : '0;
    end

    always_comb begin
        d_instr_d = d_instr_q;
        d_valid_d = d_valid_q;
        if (accept) begin
            d_instr_d = in_instr;
            d_valid_d = 1'b1;
        end else if (issue || br_resolve) begin
            d_valid_d = 1'b0;
        end

        word_d      = word_q;
        out_valid_d = out_valid_q;
        if (issue) begin
            word_d      = next_word;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        br_taken_d  = br_resolve && br_cond;
        br_off_d    = (br_resolve && br_cond) ? sext_imm(imm_f) : br_off_q;
        illegal_d   = illegal_q | (d_valid_q & dec.illegal);
        stall_cnt_d = hazard ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // ---- EX output register, branch redirect and RUN/FLUSH FSM ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_instr_q   <= '0;
            d_valid_q   <= 1'b0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            br_taken_q  <= 1'b0;
            br_off_q    <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            state_q     <= ST_RUN;
        end else begin
            d_instr_q   <= d_instr_d;
            d_valid_q   <= d_valid_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            br_taken_q  <= br_taken_d;
            br_off_q    <= br_off_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            case (state_q)
                ST_RUN:   if (br_resolve && br_cond) state_q <= ST_FLUSH;
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign out_alu_op     = word_q.ctrl.alu_op;
    assign out_src_a      = word_q.src_a;
    assign out_src_b      = word_q.src_b;
    assign out_store_data = word_q.store_data;
    assign out_mem_we     = word_q.ctrl.mem_we;
    assign out_wb_en      = word_q.ctrl.wb_en;
    assign out_wb_sel     = word_q.ctrl.wb_sel;
    assign out_rd         = word_q.rd;
    assign out_rs1        = word_q.rs1;
    assign out_rs2        = word_q.rs2;
    assign branch_taken   = br_taken_q;
    assign branch_offset  = br_off_q;
    assign illegal        = illegal_q;
    assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_param.sv
module tb_id_stage_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [2:0]  rf_addr1, rf_addr2;
    logic [15:0] rf_data1, rf_data2;
    logic        ex_is_load;
    logic [2:0]  ex_rd;
    logic        out_valid, out_ready;
    logic [2:0]  out_alu_op;
    logic [15:0] out_src_a, out_src_b, out_store_data;
    logic        out_mem_we, out_wb_en, out_wb_sel;
    logic [2:0]  out_rd, out_rs1, out_rs2;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        illegal;
    logic [15:0] stall_count;

    logic [15:0] rf [8];
    logic [62:0] exp_q [$];
    logic [62:0] obs_w;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_param #(.DATA_W(16), .RA_W(3), .OP_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_src_a(out_src_a), .out_src_b(out_src_b),
        .out_store_data(out_store_data), .out_mem_we(out_mem_we),
        .out_wb_en(out_wb_en), .out_wb_sel(out_wb_sel),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .branch_taken(branch_taken), .branch_offset(branch_offset),
        .illegal(illegal), .stall_count(stall_count)
    );

    assign rf_data1 = rf[rf_addr1];
    assign rf_data2 = rf[rf_addr2];
    assign obs_w = {out_alu_op, out_src_a, out_src_b, out_store_data,
                    out_mem_we, out_wb_en, out_wb_sel, out_rd, out_rs1, out_rs2};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_r(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] mk_i(input logic [3:0] op, input logic [2:0] rd,
                                         input logic [2:0] rs, input logic [5:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // Reference decode of one instruction into the expected EX word.
    function automatic logic [62:0] exp_word(input logic [15:0] ins);
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt, alu, ord, r1, r2;
        logic [15:0] sx, a, b, sd;
        logic        we, wb, sel;
        op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
        sx = {{10{ins[5]}}, ins[5:0]};
        alu = 3'd0; we = 1'b0; wb = 1'b0; sel = 1'b0;
        ord = 3'd0; r1 = 3'd0; r2 = 3'd0; sd = 16'd0;
        a = rf[rs];
        b = (op == 4'd11) ? rf[rd] : rf[rt];
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                alu = op[2:0]; wb = 1'b1; ord = rd; r1 = rs; r2 = rt;
            end
            4'd9:  begin alu = 3'd1; b = sx; wb = 1'b1; ord = rd; r1 = rs; end
            4'd10: begin alu = 3'd1; b = sx; wb = 1'b1; sel = 1'b1; ord = rd; r1 = rs; end
            4'd11: begin alu = 3'd1; b = sx; we = 1'b1; sd = rf[rd]; r1 = rs; r2 = rd; end
            default: ;
        endcase
        return {alu, a, b, sd, we, wb, sel, ord, r1, r2};
    endfunction

    // Scoreboard: every word EX takes must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            check("sb_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("ex_word", obs_w, exp_q.pop_front());
        end
    end

    task automatic send(input logic [15:0] ins, input bit has_word);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                if (has_word) exp_q.push_back(exp_word(ins));
                #1;
                done = 1'b1;
            end
        end
        if (!done) check("accept_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_use(input logic [2:0] erd, input bit stall, input logic [15:0] cnt0);
        send(mk_r(4'd1, 3'd5, 3'd2, 3'd3), 1'b1);
        ex_is_load = 1'b1;
        ex_rd = erd;
        @(posedge clk); #1;
        ex_is_load = 1'b0;
        ex_rd = 3'd0;
        check("lu_first_cycle_valid", out_valid, !stall);
        check("lu_count", stall_count, cnt0 + 16'(stall));
        @(posedge clk); #1;
        check("lu_second_cycle_valid", out_valid, stall);
        check("lu_count_hold", stall_count, cnt0 + 16'(stall));
        idle(3);
    endtask

    initial begin
        logic [15:0] a_ins;
        rst = 1'b0; in_valid = 1'b0; in_instr = '0;
        ex_is_load = 1'b0; ex_rd = '0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) rf[i] = 16'(16'h1000 + i * 16'h0111);
        rf[1] = 16'h0000;
        rf[6] = 16'h0005;

        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_word", obs_w, 0);
        check("rst_branch", {branch_taken, branch_offset}, 0);
        check("rst_illegal", illegal, 0);
        check("rst_stall", stall_count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        idle(1);

        // back-to-back ADD then ADDI with -3
        send(mk_r(4'd1, 3'd1, 3'd2, 3'd3), 1'b1);
        send(mk_i(4'd9, 3'd4, 3'd1, 6'h3D), 1'b1);
        @(negedge clk);
        check("stream_w0_valid", out_valid, 1);
        @(negedge clk);
        check("stream_w1_valid", out_valid, 1);
        check("addi_src_b", out_src_b, 16'hFFFD);
        idle(3);

        // mixed opcodes through the scoreboard
        send(mk_r(4'd2, 3'd3, 3'd4, 3'd5), 1'b1);
        send(mk_i(4'd10, 3'd6, 3'd2, 6'h05), 1'b1);
        send(mk_i(4'd11, 3'd7, 3'd2, 6'h38), 1'b1);
        send(16'h0000, 1'b1);
        send(mk_r(4'd5, 3'd2, 3'd7, 3'd4), 1'b1);
        idle(3);

        // load-use: matching EX load stalls once, non-matching does not
        check("stall_pre", stall_count, 0);
        load_use(3'd2, 1'b1, 16'd0);
        load_use(3'd7, 1'b0, 16'd1);

        // taken branch: pulse one cycle later, ready low for two cycles
        send(mk_i(4'd12, 3'd0, 3'd1, 6'h3E), 1'b0);
        @(negedge clk);
        check("bt_resolve_ready", in_ready, 0);
        check("bt_resolve_pulse", branch_taken, 0);
        @(negedge clk);
        check("bt_pulse", branch_taken, 1);
        check("bt_offset", branch_offset, 16'hFFFE);
        check("bt_flush_ready", in_ready, 0);
        check("bt_no_word", out_valid, 0);
        @(negedge clk);
        check("bt_pulse_end", branch_taken, 0);
        check("bt_ready_back", in_ready, 1);
        idle(1);

        // not-taken branch: no pulse, ready low for one cycle
        send(mk_i(4'd12, 3'd0, 3'd6, 6'h01), 1'b0);
        @(negedge clk);
        check("bn_resolve_ready", in_ready, 0);
        @(negedge clk);
        check("bn_no_pulse", branch_taken, 0);
        check("bn_ready_back", in_ready, 1);
        check("bn_no_word", out_valid, 0);
        idle(1);

        // backpressure: output word stable, D fills, then drain in order
        out_ready = 1'b0;
        a_ins = mk_r(4'd3, 3'd1, 3'd4, 3'd5);
        send(a_ins, 1'b1);
        send(mk_r(4'd4, 3'd2, 3'd5, 3'd6), 1'b1);
        in_valid = 1'b1;
        in_instr = mk_i(4'd9, 3'd3, 3'd7, 6'h02);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_word_stable", obs_w, exp_word(a_ins));
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(mk_i(4'd9, 3'd3, 3'd7, 6'h02), 1'b1);
        idle(4);

        // illegal opcode: NOP word and sticky flag
        check("illegal_pre", illegal, 0);
        send(mk_r(4'd15, 3'd1, 3'd2, 3'd3), 1'b1);
        idle(3);
        check("illegal_set", illegal, 1);
        send(mk_r(4'd1, 3'd2, 3'd3, 3'd4), 1'b1);
        idle(3);
        check("illegal_sticky", illegal, 1);

        // reset asserted during FLUSH with a held output word
        out_ready = 1'b0;
        send(mk_r(4'd1, 3'd5, 3'd2, 3'd3), 1'b1);
        send(mk_i(4'd12, 3'd0, 3'd1, 6'h3E), 1'b0);
        @(posedge clk); #2;
        check("pre_rst_pulse", branch_taken, 1);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_word", obs_w, 0);
        check("mid_rst_branch", {branch_taken, branch_offset}, 0);
        check("mid_rst_illegal", illegal, 0);
        check("mid_rst_stall", stall_count, 0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        send(mk_r(4'd6, 3'd4, 3'd3, 3'd2), 1'b1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
